// File: rtl/uart_pkg.sv
// Shared UART constants, FSM encodings and width helper for the rx/tx pair.
// No logic of its own.
package uart_pkg;

  localparam int BAUD_CNT_DFLT = 5208;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP
  } rx_state_e;

  // Ceiling log2, never narrower than one bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Receiver-side bundle: serial line in, delivered word and flags out.
// master = receiver, slave = line driver / word consumer.
interface uart_rx_cfg_if #(
  parameter int DATA_W = 8
);
  logic              din;
  logic [DATA_W-1:0] dout;
  logic              dout_vld;
  logic              parity_err;
  logic              frame_err;

  modport master (input din, output dout, dout_vld, parity_err, frame_err);
  modport slave  (output din, input dout, dout_vld, parity_err, frame_err);
endinterface

// File: rtl/uart_baud_cnt.sv
// Bit timer: counts 0..CNT_MAX-1 while enabled, clear has priority.
// Strobes are combinational from the count; no backpressure.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CNT_MAX = BAUD_CNT_DFLT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic smp,
  output logic bit_end
);
  localparam int CW = clog2(CNT_MAX);

  logic [CW-1:0] cnt;

  assign smp     = (cnt == CW'(CNT_MAX / 2 - 1));
  assign bit_end = (cnt == CW'(CNT_MAX - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= bit_end ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver; word and flags appear one cycle after the last stop-bit sample.
// No backpressure: dout_vld is a single-cycle strobe the consumer must take.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CNT_MAX   = BAUD_CNT_DFLT,
  parameter int DATA_W    = 8,
  parameter int PARITY    = PAR_NONE,
  parameter int STOP_BITS = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_rx_cfg_if.master rx
);
  localparam int IW = clog2(DATA_W + 1);

  rx_state_e state, state_nxt;

  logic              din_s1, din_s2, din_s3;
  logic              fall;
  logic              smp, bit_end;
  logic              cnt_clr, cnt_en;
  logic [DATA_W-1:0] shreg;
  logic [IW-1:0]     bit_idx;
  logic              par_acc, ferr_acc;
  logic              idx_clr, idx_inc, shift_en, par_smp, stop_smp, deliver;
  logic              odd_mode;
  logic [DATA_W-1:0] dout_q;
  logic              dout_vld_q, par_err_q, frame_err_q;

  assign odd_mode = (PARITY == PAR_ODD);
  // din_s3 is the previous synchronised value, used only for edge detection.
  assign fall     = din_s3 & ~din_s2;
  assign cnt_en   = (state != ST_IDLE);

  uart_baud_cnt #(.CNT_MAX(CNT_MAX)) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .smp     (smp),
    .bit_end (bit_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    idx_clr   = 1'b0;
    idx_inc   = 1'b0;
    shift_en  = 1'b0;
    par_smp   = 1'b0;
    stop_smp  = 1'b0;
    deliver   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (fall) begin
          cnt_clr   = 1'b1;
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (smp && din_s2) begin
          state_nxt = ST_IDLE;
        end else if (bit_end) begin
          idx_clr   = 1'b1;
          state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (smp) begin
          shift_en = 1'b1;
          idx_inc  = 1'b1;
        end
        if (bit_end && bit_idx == IW'(DATA_W)) begin
          idx_clr   = 1'b1;
          state_nxt = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
        end
      end
      ST_PAR: begin
        if (smp) par_smp = 1'b1;
        if (bit_end) begin
          idx_clr   = 1'b1;
          state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (smp) begin
          stop_smp = 1'b1;
          // Leave at mid-bit so a start edge right after the stop bit is caught.
          if (bit_idx == IW'(STOP_BITS - 1)) begin
            deliver   = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            idx_inc = 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_s1      <= 1'b1;
      din_s2      <= 1'b1;
      din_s3      <= 1'b1;
      shreg       <= '0;
      bit_idx     <= '0;
      par_acc     <= 1'b0;
      ferr_acc    <= 1'b0;
      dout_q      <= '0;
      dout_vld_q  <= 1'b0;
      par_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      din_s1     <= rx.din;
      din_s2     <= din_s1;
      din_s3     <= din_s2;
      dout_vld_q <= deliver;
      if (cnt_clr) begin
        par_acc  <= 1'b0;
        ferr_acc <= 1'b0;
      end
      if (idx_clr)      bit_idx <= '0;
      else if (idx_inc) bit_idx <= bit_idx + 1'b1;
      if (shift_en) shreg <= {din_s2, shreg[DATA_W-1:1]};
      // XOR of data and parity bit must be 1 (odd) or 0 (even).
      if (par_smp)  par_acc <= (^shreg) ^ din_s2 ^ odd_mode;
      if (stop_smp) ferr_acc <= ferr_acc | ~din_s2;
      if (deliver) begin
        dout_q      <= shreg;
        par_err_q   <= par_acc;
        frame_err_q <= ferr_acc | ~din_s2;
      end
    end
  end

  assign rx.dout       = dout_q;
  assign rx.dout_vld   = dout_vld_q;
  assign rx.parity_err = par_err_q;
  assign rx.frame_err  = frame_err_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: five receiver configurations at 10 clocks per bit,
// strobes captured into a scoreboard queue and checked with immediate assertions.
module tb_uart_rx_cfg;
  localparam int CNT = 10;

  typedef struct {
    int         sel;
    logic [8:0] d;
    logic       pe;
    logic       fe;
  } rec_t;

  logic       clk;
  logic       rst_n;
  logic [4:0] din_line;
  logic [4:0] vld, pe, fe, vld_prev;
  logic [8:0] dat [5];
  rec_t       q[$];
  rec_t       r;
  int         n_assert;
  int         n_fail;
  int         long_cnt;

  uart_rx_cfg_if #(.DATA_W(8)) if0 ();
  uart_rx_cfg_if #(.DATA_W(8)) if1 ();
  uart_rx_cfg_if #(.DATA_W(8)) if2 ();
  uart_rx_cfg_if #(.DATA_W(8)) if3 ();
  uart_rx_cfg_if #(.DATA_W(7)) if4 ();

  uart_rx_cfg #(.CNT_MAX(CNT), .DATA_W(8), .PARITY(0), .STOP_BITS(1)) dut0 (.clk(clk), .rst_n(rst_n), .rx(if0));
  uart_rx_cfg #(.CNT_MAX(CNT), .DATA_W(8), .PARITY(2), .STOP_BITS(1)) dut1 (.clk(clk), .rst_n(rst_n), .rx(if1));
  uart_rx_cfg #(.CNT_MAX(CNT), .DATA_W(8), .PARITY(1), .STOP_BITS(1)) dut2 (.clk(clk), .rst_n(rst_n), .rx(if2));
  uart_rx_cfg #(.CNT_MAX(CNT), .DATA_W(8), .PARITY(0), .STOP_BITS(2)) dut3 (.clk(clk), .rst_n(rst_n), .rx(if3));
  uart_rx_cfg #(.CNT_MAX(CNT), .DATA_W(7), .PARITY(0), .STOP_BITS(2)) dut4 (.clk(clk), .rst_n(rst_n), .rx(if4));

  assign if0.din = din_line[0];
  assign if1.din = din_line[1];
  assign if2.din = din_line[2];
  assign if3.din = din_line[3];
  assign if4.din = din_line[4];

  assign vld = {if4.dout_vld, if3.dout_vld, if2.dout_vld, if1.dout_vld, if0.dout_vld};
  assign pe  = {if4.parity_err, if3.parity_err, if2.parity_err, if1.parity_err, if0.parity_err};
  assign fe  = {if4.frame_err, if3.frame_err, if2.frame_err, if1.frame_err, if0.frame_err};
  assign dat[0] = {1'b0, if0.dout};
  assign dat[1] = {1'b0, if1.dout};
  assign dat[2] = {1'b0, if2.dout};
  assign dat[3] = {1'b0, if3.dout};
  assign dat[4] = {2'b00, if4.dout};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    vld_prev = '0;
    long_cnt = 0;
  end

  always @(negedge clk) begin
    for (int i = 0; i < 5; i++) begin
      if (vld[i]) q.push_back('{sel: i, d: dat[i], pe: pe[i], fe: fe[i]});
      if (vld[i] && vld_prev[i]) long_cnt++;
    end
    vld_prev = vld;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rec(input string tag, input int sel, input logic [8:0] d, input logic p, input logic f);
    chk({tag, "_present"}, 32'(q.size() != 0), 32'd1);
    if (q.size() != 0) begin
      r = q.pop_front();
      chk({tag, "_sel"}, 32'(r.sel), 32'(sel));
      chk({tag, "_dout"}, 32'(r.d), 32'(d));
      chk({tag, "_parity_err"}, 32'(r.pe), 32'(p));
      chk({tag, "_frame_err"}, 32'(r.fe), 32'(f));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input int sel, input logic b);
    din_line[sel] = b;
    idle(CNT);
  endtask

  // pbit < 0 means no parity bit; last_stop is the value of the final stop bit.
  task automatic send_frame(input int sel, input logic [8:0] d, input int nb, input int pbit,
                            input int nstop, input logic last_stop);
    drive_bit(sel, 1'b0);
    for (int i = 0; i < nb; i++) drive_bit(sel, d[i]);
    if (pbit >= 0) drive_bit(sel, pbit[0]);
    for (int i = 0; i < nstop; i++) drive_bit(sel, (i == nstop - 1) ? last_stop : 1'b1);
    din_line[sel] = 1'b1;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    din_line = '1;
    rst_n    = 1'b0;

    // Reset state
    idle(3);
    chk("rst_dout", 32'(if0.dout), 32'h0);
    chk("rst_vld", 32'(vld), 32'h0);
    chk("rst_perr", 32'(pe), 32'h0);
    chk("rst_ferr", 32'(fe), 32'h0);
    rst_n = 1'b1;
    idle(20);
    chk("idle_no_strobe", 32'(q.size()), 32'd0);

    // Plain 8N1 word
    send_frame(0, 9'h35, 8, -1, 1, 1'b1);
    idle(10);
    chk_rec("w35", 0, 9'h35, 1'b0, 1'b0);
    chk("w35_hold", 32'(if0.dout), 32'h35);

    // Short glitch rejected, then a real frame
    din_line[0] = 1'b0;
    idle(3);
    din_line[0] = 1'b1;
    idle(20);
    chk("glitch_no_strobe", 32'(q.size()), 32'd0);
    send_frame(0, 9'hA5, 8, -1, 1, 1'b1);
    idle(10);
    chk_rec("wA5", 0, 9'hA5, 1'b0, 1'b0);
    chk("wA5_single", 32'(q.size()), 32'd0);

    // Parity: 0x07 has three ones
    send_frame(1, 9'h07, 8, 0, 1, 1'b1);
    idle(10);
    chk_rec("even_p0", 1, 9'h07, 1'b1, 1'b0);
    send_frame(1, 9'h07, 8, 1, 1, 1'b1);
    idle(10);
    chk_rec("even_p1", 1, 9'h07, 1'b0, 1'b0);
    send_frame(2, 9'h07, 8, 0, 1, 1'b1);
    idle(10);
    chk_rec("odd_p0", 2, 9'h07, 1'b0, 1'b0);
    send_frame(2, 9'h07, 8, 1, 1, 1'b1);
    idle(10);
    chk_rec("odd_p1", 2, 9'h07, 1'b1, 1'b0);

    // Two stop bits: bad second stop, one idle bit to re-arm, then back-to-back frames
    send_frame(3, 9'h11, 8, -1, 2, 1'b0);
    drive_bit(3, 1'b1);
    send_frame(3, 9'h22, 8, -1, 2, 1'b1);
    send_frame(3, 9'h33, 8, -1, 2, 1'b1);
    idle(10);
    chk_rec("s2_11", 3, 9'h11, 1'b0, 1'b1);
    chk_rec("s2_22", 3, 9'h22, 1'b0, 1'b0);
    chk_rec("s2_33", 3, 9'h33, 1'b0, 1'b0);
    send_frame(4, 9'h5A, 7, -1, 2, 1'b0);
    drive_bit(4, 1'b1);
    send_frame(4, 9'h22, 7, -1, 2, 1'b1);
    send_frame(4, 9'h33, 7, -1, 2, 1'b1);
    idle(10);
    chk_rec("w7_5A", 4, 9'h5A, 1'b0, 1'b1);
    chk_rec("w7_22", 4, 9'h22, 1'b0, 1'b0);
    chk_rec("w7_33", 4, 9'h33, 1'b0, 1'b0);
    chk("s2_no_extra", 32'(q.size()), 32'd0);

    // Reset during data bit 4 of 0x3C
    drive_bit(0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(0, (8'h3C >> i) & 8'h1);
    din_line[0] = 1'b1;
    idle(3);
    rst_n = 1'b0;
    #1;
    chk("midrst_dout", 32'(if0.dout), 32'h0);
    chk("midrst_vld", 32'(if0.dout_vld), 32'h0);
    idle(3);
    rst_n = 1'b1;
    idle(30);
    chk("midrst_no_strobe", 32'(q.size()), 32'd0);
    send_frame(0, 9'h96, 8, -1, 1, 1'b1);
    idle(10);
    chk_rec("w96", 0, 9'h96, 1'b0, 1'b0);

    // Break: one errored frame, no re-trigger while held low
    din_line[0] = 1'b0;
    idle(15 * CNT);
    din_line[0] = 1'b1;
    idle(20);
    chk_rec("break", 0, 9'h00, 1'b0, 1'b1);
    chk("break_single", 32'(q.size()), 32'd0);

    chk("vld_one_cycle", 32'(long_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised UART receiver, the successor to the fixed 8N1 receiver in the temperature-monitor serial path. It supports configurable data width, optional odd/even parity, and 1 or 2 stop bits. It adds a din synchroniser, false-start rejection, and parity/framing error flags. It sits between the board RX pin and the command parser, delivering one word per frame with a single-cycle valid strobe.

Parameters:
CNT_MAX, 5208, clocks per bit (50 MHz / 9600 baud); minimum 4.
DATA_W, 8, data bits per frame; legal range 5..9.
PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
din  input  1  serial line; idles high; asynchronous to clk
dout  output  DATA_W  received word, LSB = first data bit on the line
dout_vld  output  1  one-cycle strobe; dout, parity_err and frame_err are valid in this cycle
parity_err  output  1  parity mismatch in the frame being delivered (always 0 when PARITY = 0)
frame_err  output  1  at least one stop bit was sampled low in the frame being delivered

Behaviour:
- Reset: dout = 0, dout_vld = 0, parity_err = 0, frame_err = 0. Synchroniser flops reset to 1. FSM resets to IDLE; bit timer and bit index reset to 0.
- Synchronisation: din passes through a 2-flop synchroniser. Start is detected on a 1->0 transition of the synchronised signal.
- Bit timer: cnt counts 0..CNT_MAX-1 and wraps. It is cleared and started on start detection. The sample point is cnt == CNT_MAX/2 - 1 (integer division).
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE -> START on start detection.
  - START: at the sample point, a sampled 1 is a false start; return to IDLE with no outputs changed. A sampled 0 stays in START; at bit end (cnt == CNT_MAX-1) go to DATA.
  - DATA: sample each bit at its sample point and shift it in LSB-first. After DATA_W bits, at bit end, go to PAR if PARITY != 0, otherwise go to STOP.
  - PAR: sample the parity bit. Parity is checked over data bits plus the parity bit:
    - odd mode: XOR must equal 1;
    - even mode: XOR must equal 0.
    At bit end go to STOP.
  - STOP: sample each of the STOP_BITS stop bits. Any sampled 0 sets the frame_err flag. At the sample point of the last stop bit, go to IDLE immediately (do not wait for bit end).
- Delivery: dout_vld rises in the clock cycle after the last stop-bit sample point and lasts exactly one cycle. dout, parity_err and frame_err update in that same cycle and hold until the next delivery. Frames with errors are still delivered with dout_vld = 1.
- Back-to-back frames: because STOP exits at mid-bit, a start edge arriving any time after the last stop-bit sample point is accepted. No idle gap between frames is required.
- A line held low (break) produces a frame with frame_err = 1. The receiver then waits in IDLE for a fresh 1->0 edge and does not re-trigger on a continuously low line.
- Reset mid-frame (rst_n low at any time): immediate return to reset values; no dout_vld is produced for the partial frame.
- Width rules: cnt width = clog2(CNT_MAX). Bit index width = clog2(DATA_W + 1). Shift register width = DATA_W.

Decomposition:
- Shared package uart_pkg holds:
  - parity constants PAR_NONE = 0, PAR_ODD = 1, PAR_EVEN = 2;
  - FSM state encodings;
  - a clog2 function;
  - the default baud constant 5208. The package is reused by the future uart_tx_cfg.
- One sub-module, uart_baud_cnt: bit timer with clear/enable inputs and sample/end strobe outputs. It is shared with uart_tx_cfg.

Test Plan:
1. CNT_MAX = 10; hold rst_n low 3 cycles with din = 1, then idle 20 cycles -> all outputs 0, no dout_vld.
2. CNT_MAX = 10, DATA_W = 8, PARITY = 0; send 0x35 -> dout = 0x35, single-cycle dout_vld, parity_err = 0, frame_err = 0.
3. Drive din low for 3 cycles only, then send valid frame 0xA5 -> no strobe for the glitch; exactly one strobe with dout = 0xA5.
4. PARITY = 2 (even); send 0x07 with parity bit 0 -> dout = 0x07, parity_err = 1. Resend with parity bit 1 -> parity_err = 0. Repeat with PARITY = 1 (odd) and the opposite expectations.
5. STOP_BITS = 2; send 0x11 with the second stop bit 0, then 0x22 and 0x33 back-to-back with no idle gap -> three strobes in order; first has frame_err = 1, the other two are clean. Repeat with DATA_W = 7 and 0x5A.
6. Assert rst_n low during data bit 4 of frame 0x3C; release, then send 0x96 -> no strobe for the aborted frame; dout = 0x96 with no error flags.
